// File: rtl/regfile_stream_if.sv
// Bus bundle for regfile_stream: core read/write ports plus the streamed
// load/dump engine handshakes.
interface regfile_stream_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [2:0]      rwe;
  logic [AW-1:0]   Addr_D;
  logic [XLEN-1:0] Data_D;
  logic [AW-1:0]   Addr_A;
  logic [AW-1:0]   Addr_B;
  logic [XLEN-1:0] Data_A;
  logic [XLEN-1:0] Data_B;
  logic            load_start;
  logic            load_valid;
  logic [XLEN-1:0] load_data;
  logic            load_ready;
  logic            dump_start;
  logic            dump_ready;
  logic            dump_valid;
  logic [XLEN-1:0] dump_data;
  logic [AW-1:0]   dump_addr;
  logic            busy;
  logic            done;

  modport slave (
    input  rwe, Addr_D, Data_D, Addr_A, Addr_B,
    input  load_start, load_valid, load_data, dump_start, dump_ready,
    output Data_A, Data_B, load_ready, dump_valid, dump_data, dump_addr,
    output busy, done
  );

  modport master (
    output rwe, Addr_D, Data_D, Addr_A, Addr_B,
    output load_start, load_valid, load_data, dump_start, dump_ready,
    input  Data_A, Data_B, load_ready, dump_valid, dump_data, dump_addr,
    input  busy, done
  );
endinterface

// File: rtl/regfile_stream.sv
// NREGS x XLEN register file (x0 hard-wired to zero) with sub-word writes,
// optional write-to-read bypass and a one-register-per-beat load/dump engine.
module regfile_stream #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input logic              clk,
  input logic              reset,
  regfile_stream_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DUMP = 2'd2;

  logic [XLEN-1:0] regs [NREGS];
  logic [1:0]      state;
  logic [AW-1:0]   ptr;
  logic            done_q;
  logic [XLEN-1:0] wv;
  logic            busy_w;
  logic            core_we;
  logic            last_beat;

  // Sub-word writes are extended to a full word before they reach the array.
  always_comb begin
    wv = bus.Data_D;
    case (bus.rwe)
      3'd2: begin
        wv       = {XLEN{bus.Data_D[15]}};
        wv[15:0] = bus.Data_D[15:0];
      end
      3'd3: begin
        wv      = {XLEN{bus.Data_D[7]}};
        wv[7:0] = bus.Data_D[7:0];
      end
      3'd4: begin
        wv       = '0;
        wv[15:0] = bus.Data_D[15:0];
      end
      3'd5: begin
        wv      = '0;
        wv[7:0] = bus.Data_D[7:0];
      end
      default: wv = bus.Data_D;
    endcase
  end

  assign busy_w    = (state != IDLE);
  assign core_we   = (bus.rwe >= 3'd1) && (bus.rwe <= 3'd5) &&
                     (bus.Addr_D != '0) && !busy_w;
  assign last_beat = (ptr == AW'(NREGS - 1));

  assign bus.Data_A = (bus.Addr_A == '0) ? '0 :
                      ((BYPASS != 0) && core_we && (bus.Addr_D == bus.Addr_A)) ? wv :
                      regs[bus.Addr_A];
  assign bus.Data_B = (bus.Addr_B == '0) ? '0 :
                      ((BYPASS != 0) && core_we && (bus.Addr_D == bus.Addr_B)) ? wv :
                      regs[bus.Addr_B];

  assign bus.busy       = busy_w;
  assign bus.done       = done_q;
  assign bus.load_ready = (state == LOAD);
  assign bus.dump_valid = (state == DUMP);
  assign bus.dump_addr  = ptr;
  assign bus.dump_data  = (ptr == '0) ? '0 : regs[ptr];

  // Engine and core write share the array; the core port is blocked while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      state  <= IDLE;
      ptr    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_start) begin
            state <= LOAD;
            ptr   <= AW'(1);
          end else if (bus.dump_start) begin
            state <= DUMP;
            ptr   <= '0;
          end
        end
        LOAD: begin
          if (bus.load_valid) begin
            regs[ptr] <= bus.load_data;
            ptr       <= ptr + AW'(1);
            if (last_beat) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        DUMP: begin
          if (bus.dump_ready) begin
            ptr <= ptr + AW'(1);
            if (last_beat) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (core_we) regs[bus.Addr_D] <= wv;
    end
  end
endmodule

// File: tb/tb_regfile_stream.sv
// Randomized bench for regfile_stream: an array/queue reference model checked
// every cycle, plus directed literal expectations for write modes, bypass and streams.
module tb_regfile_stream;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  regfile_stream_if #(.XLEN(XLEN), .AW(AW)) bus ();
  regfile_stream_if #(.XLEN(XLEN), .AW(AW)) bus0 ();

  regfile_stream #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  regfile_stream #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  assign bus0.rwe        = bus.rwe;
  assign bus0.Addr_D     = bus.Addr_D;
  assign bus0.Data_D     = bus.Data_D;
  assign bus0.Addr_A     = bus.Addr_A;
  assign bus0.Addr_B     = bus.Addr_B;
  assign bus0.load_start = bus.load_start;
  assign bus0.load_valid = bus.load_valid;
  assign bus0.load_data  = bus.load_data;
  assign bus0.dump_start = bus.dump_start;
  assign bus0.dump_ready = bus.dump_ready;

  always #5 clk = ~clk;

  int compares = 0;
  int fails    = 0;
  int done_cnt = 0;
  bit chk_en   = 1'b0;

  // Reference model: architectural contents plus engine mode/index.
  logic [31:0] m [NREGS];
  int m_mode = 0;
  int m_idx  = 0;
  bit m_done = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wval(input logic [2:0] md, input logic [31:0] d);
    case (md)
      3'd1: return d;
      3'd2: return 32'($signed(d[15:0]));
      3'd3: return 32'($signed(d[7:0]));
      3'd4: return {16'h0, d[15:0]};
      3'd5: return {24'h0, d[7:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit commitNow();
    return (bus.rwe >= 3'd1) && (bus.rwe <= 3'd5) && (bus.Addr_D != 0) && (m_mode == 0);
  endfunction

  function automatic logic [31:0] expRead(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && commitNow() && bus.Addr_D == a) return wval(bus.rwe, bus.Data_D);
    return m[a];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) m[i] = 32'h0;
      m_mode = 0;
      m_idx  = 0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (commitNow()) m[bus.Addr_D] = wval(bus.rwe, bus.Data_D);
      case (m_mode)
        0: begin
          if (bus.load_start) begin m_mode = 1; m_idx = 1; end
          else if (bus.dump_start) begin m_mode = 2; m_idx = 0; end
        end
        1: if (bus.load_valid) begin
          m[m_idx] = bus.load_data;
          if (m_idx == NREGS - 1) begin m_mode = 0; m_done = 1'b1; end
          else m_idx++;
        end
        2: if (bus.dump_ready) begin
          if (m_idx == NREGS - 1) begin m_mode = 0; m_done = 1'b1; end
          else m_idx++;
        end
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset && bus.done) done_cnt++;
    if (chk_en && !reset) begin
      checkOutput("Data_A", bus.Data_A, expRead(bus.Addr_A, 1'b1));
      checkOutput("Data_B", bus.Data_B, expRead(bus.Addr_B, 1'b1));
      checkOutput("Data_A_nobyp", bus0.Data_A, expRead(bus.Addr_A, 1'b0));
      checkOutput("Data_B_nobyp", bus0.Data_B, expRead(bus.Addr_B, 1'b0));
      checkOutput("busy", {31'h0, bus.busy}, {31'h0, m_mode != 0});
      checkOutput("busy_nobyp", {31'h0, bus0.busy}, {31'h0, m_mode != 0});
      checkOutput("done", {31'h0, bus.done}, {31'h0, m_done});
      checkOutput("load_ready", {31'h0, bus.load_ready}, {31'h0, m_mode == 1});
      checkOutput("dump_valid", {31'h0, bus.dump_valid}, {31'h0, m_mode == 2});
      if (m_mode == 2) begin
        checkOutput("dump_addr", {27'h0, bus.dump_addr}, 32'(m_idx));
        checkOutput("dump_data", bus.dump_data, m[m_idx]);
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] rwe, input logic [AW-1:0] ad, input logic [31:0] dd,
                               input logic [AW-1:0] aa, input logic [AW-1:0] ab);
    bus.rwe    = rwe;
    bus.Addr_D = ad;
    bus.Data_D = dd;
    bus.Addr_A = aa;
    bus.Addr_B = ab;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] expw [6];
    logic [31:0] dq_data [$];
    int          dq_addr [$];
    logic [31:0] prev_d;
    logic [AW-1:0] prev_a;
    bit          rdy, stalled;
    int          k, cyc, d0;

    expw[1] = 32'hABCD8F80; expw[2] = 32'hFFFF8F80; expw[3] = 32'hFFFFFF80;
    expw[4] = 32'h00008F80; expw[5] = 32'h00000080;

    applyStimulus(3'd0, '0, '0, 5'd3, 5'd4);
    bus.load_start = 0; bus.load_valid = 0; bus.load_data = 0;
    bus.dump_start = 0; bus.dump_ready = 0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    @(negedge clk);
    checkOutput("rst_busy", {31'h0, bus.busy}, 32'h0);
    checkOutput("rst_done", {31'h0, bus.done}, 32'h0);
    checkOutput("rst_read", bus.Data_A, 32'h0);
    nextCycle();

    for (int md = 1; md <= 5; md++) begin
      applyStimulus(3'(md), 5'd5, 32'hABCD8F80, 5'd5, 5'd0);
      nextCycle();
      bus.rwe = 3'd0;
      @(negedge clk);
      checkOutput("write_mode", bus.Data_A, expw[md]);
      nextCycle();
    end

    applyStimulus(3'd1, 5'd0, 32'hABCD8F80, 5'd0, 5'd0);
    @(negedge clk);
    checkOutput("x0_bypass", bus.Data_A, 32'h0);
    nextCycle();
    bus.rwe = 3'd0;
    @(negedge clk);
    checkOutput("x0_read", bus.Data_A, 32'h0);
    nextCycle();

    applyStimulus(3'd1, 5'd7, 32'h1234, 5'd7, 5'd7);
    @(negedge clk);
    checkOutput("bypass_on", bus.Data_A, 32'h1234);
    checkOutput("bypass_off", bus0.Data_A, 32'h0);
    nextCycle();
    bus.rwe = 3'd0;
    @(negedge clk);
    checkOutput("bypass_off_next", bus0.Data_A, 32'h1234);
    nextCycle();

    for (int i = 0; i < 150; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
      nextCycle();
    end

    // Load with a simultaneous dump_start: load must win.
    d0 = done_cnt;
    applyStimulus(3'd0, '0, '0, 5'd0, 5'd0);
    bus.load_start = 1; bus.dump_start = 1;
    nextCycle();
    bus.load_start = 0; bus.dump_start = 0;
    checkOutput("collision_load", {31'h0, bus.load_ready}, 32'h1);
    k = 1; cyc = 0;
    while (k < NREGS && cyc < 200) begin
      bus.load_valid = (cyc % 2 == 0);
      bus.load_data  = 32'h100 + 32'(k);
      applyStimulus(3'd1, 5'($urandom_range(1, 31)), $urandom, 5'($urandom), 5'($urandom));
      bus.dump_start = (cyc == 5);
      @(negedge clk);
      rdy = bus.load_ready;
      @(posedge clk);
      if (bus.load_valid && rdy) k++;
      #1;
      cyc++;
    end
    bus.load_valid = 0; bus.dump_start = 0; bus.rwe = 3'd0;
    checkOutput("load_beats", 32'(k), 32'(NREGS));
    nextCycle();
    checkOutput("load_done_cnt", 32'(done_cnt - d0), 32'h1);
    for (int i = 0; i < NREGS; i++) begin
      bus.Addr_A = 5'(i); bus.Addr_B = 5'(NREGS - 1 - i);
      @(negedge clk);
      checkOutput("load_read", bus.Data_A, (i == 0) ? 32'h0 : 32'h100 + 32'(i));
      nextCycle();
    end

    // Dump with random backpressure.
    d0 = done_cnt;
    bus.dump_start = 1;
    nextCycle();
    bus.dump_start = 0;
    stalled = 0; cyc = 0;
    while (dq_data.size() < NREGS && cyc < 400) begin
      bus.dump_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (stalled) begin
        checkOutput("dump_stall_data", bus.dump_data, prev_d);
        checkOutput("dump_stall_addr", {27'h0, bus.dump_addr}, {27'h0, prev_a});
      end
      if (bus.dump_valid && bus.dump_ready) begin
        dq_data.push_back(bus.dump_data);
        dq_addr.push_back(int'(bus.dump_addr));
      end
      stalled = bus.dump_valid && !bus.dump_ready;
      prev_d  = bus.dump_data;
      prev_a  = bus.dump_addr;
      nextCycle();
      cyc++;
    end
    bus.dump_ready = 0;
    checkOutput("dump_beats", 32'(dq_data.size()), 32'(NREGS));
    for (int i = 0; i < dq_data.size(); i++) begin
      checkOutput("dump_seq_addr", 32'(dq_addr[i]), 32'(i));
      checkOutput("dump_seq_data", dq_data[i], (i == 0) ? 32'h0 : 32'h100 + 32'(i));
    end
    nextCycle();
    checkOutput("dump_done_cnt", 32'(done_cnt - d0), 32'h1);

    // Reset after ten load beats: everything clears and done never fires.
    d0 = done_cnt;
    bus.load_start = 1;
    nextCycle();
    bus.load_start = 0;
    k = 1; cyc = 0;
    while (k < 11 && cyc < 100) begin
      bus.load_valid = 1; bus.load_data = 32'h200 + 32'(k);
      @(negedge clk);
      rdy = bus.load_ready;
      @(posedge clk);
      if (rdy) k++;
      #1;
      cyc++;
    end
    bus.load_valid = 0;
    bus.Addr_A = 5'd1; bus.Addr_B = 5'd10;
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_busy", {31'h0, bus.busy}, 32'h0);
    checkOutput("async_rst_ready", {31'h0, bus.load_ready}, 32'h0);
    checkOutput("async_rst_A", bus.Data_A, 32'h0);
    checkOutput("async_rst_B", bus.Data_B, 32'h0);
    checkOutput("async_rst_done", {31'h0, bus.done}, 32'h0);
    nextCycle();
    reset = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      bus.Addr_A = 5'(i);
      @(negedge clk);
      checkOutput("post_rst_read", bus.Data_A, 32'h0);
      nextCycle();
    end
    checkOutput("rst_no_done", 32'(done_cnt - d0), 32'h0);

    for (int i = 0; i < 600; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
      bus.load_start = ($urandom_range(0, 7) == 0);
      bus.dump_start = ($urandom_range(0, 7) == 0);
      bus.load_valid = 1'($urandom_range(0, 1));
      bus.load_data  = $urandom;
      bus.dump_ready = 1'($urandom_range(0, 1));
      nextCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end
endmodule
